// File: rtl/fpu_ss_pkg.sv
// Shared types for the FP CSR sequencer: FSM state encoding and the
// writeback-port source selector.
package fpu_ss_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RESP   = 2'd2,
        ST_CSR_WB = 2'd3
    } seq_state_e;

    typedef logic [1:0] wb_src_t;

    localparam wb_src_t WB_SRC_NONE = 2'd0;
    localparam wb_src_t WB_SRC_FPU  = 2'd1;
    localparam wb_src_t WB_SRC_CSR  = 2'd2;

endpackage

// File: rtl/fpu_ss_csr_seq_if.sv
// Issue, FPU, CSR and integer writeback signals of the FP CSR sequencer.
// The sequencer takes the slave view; its environment takes the master view.
interface fpu_ss_csr_seq_if #(
    parameter int unsigned ID_WIDTH = 4
);
    logic                issue_valid_i;
    logic                issue_ready_o;
    logic                issue_is_csr_i;
    logic [ID_WIDTH-1:0] issue_id_i;
    logic                fpu_in_valid_o;
    logic                fpu_in_ready_i;
    logic                fpu_out_valid_i;
    logic                fpu_out_ready_o;
    logic                fpu_out_int_i;
    logic [ID_WIDTH-1:0] fpu_out_id_i;
    logic [31:0]         fpu_out_data_i;
    logic                csr_valid_o;
    logic [ID_WIDTH-1:0] csr_id_o;
    logic                csr_wb_i;
    logic [31:0]         csr_rdata_i;
    logic                wb_valid_o;
    logic                wb_ready_i;
    logic [ID_WIDTH-1:0] wb_id_o;
    logic [31:0]         wb_data_o;
    logic                busy_o;

    modport slave (
        input  issue_valid_i, issue_is_csr_i, issue_id_i, fpu_in_ready_i,
               fpu_out_valid_i, fpu_out_int_i, fpu_out_id_i, fpu_out_data_i,
               csr_wb_i, csr_rdata_i, wb_ready_i,
        output issue_ready_o, fpu_in_valid_o, fpu_out_ready_o, csr_valid_o,
               csr_id_o, wb_valid_o, wb_id_o, wb_data_o, busy_o
    );

    modport master (
        output issue_valid_i, issue_is_csr_i, issue_id_i, fpu_in_ready_i,
               fpu_out_valid_i, fpu_out_int_i, fpu_out_id_i, fpu_out_data_i,
               csr_wb_i, csr_rdata_i, wb_ready_i,
        input  issue_ready_o, fpu_in_valid_o, fpu_out_ready_o, csr_valid_o,
               csr_id_o, wb_valid_o, wb_id_o, wb_data_o, busy_o
    );
endinterface

// File: rtl/fpu_ss_csr_seq_chk.sv
// Protocol properties of the FP CSR sequencer, kept apart from the datapath.
module fpu_ss_csr_seq_chk (
    input logic clk_i,
    input logic rst_ni,
    input logic in_csr_wb,
    input logic fpu_out_valid,
    input logic fpu_out_int,
    input logic cnt_empty
);
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fpu_out_valid |-> !cnt_empty)
        else $error("fpu result arrived with no op in flight");

    a_wb_exclusive: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(in_csr_wb && fpu_out_valid && fpu_out_int))
        else $error("fpu integer result collided with csr writeback");
endmodule

// File: rtl/fpu_ss_outstanding_cnt.sv
// Up/down counter of in-flight FPU ops; saturates at both ends so a
// simultaneous dispatch and retirement leaves the count unchanged.
module fpu_ss_outstanding_cnt #(
    parameter  int unsigned MAX_OUTSTANDING = 8,
    localparam int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             full,
    output logic             empty
);
    logic [CNT_W-1:0] cnt_r;

    // In-flight count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (inc && !dec && !full) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt   = cnt_r;
    assign full  = (cnt_r == CNT_W'(MAX_OUTSTANDING));
    assign empty = (cnt_r == CNT_W'(0));
endmodule

// File: rtl/fpu_ss_csr_seq.sv
// Sequencer in front of the FP CSR unit and FPU: dispatches FP ops, holds CSR
// accesses until every in-flight op has retired, and shares the int writeback port.
module fpu_ss_csr_seq
    import fpu_ss_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned ID_WIDTH        = 4
) (
    input logic             clk_i,
    input logic             rst_ni,
    fpu_ss_csr_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    seq_state_e          state_r;
    seq_state_e          state_nxt_s;
    logic [ID_WIDTH-1:0] csr_id_r;
    logic [31:0]         data_r;
    logic [CNT_W-1:0]    outstanding_s;
    logic                full_s;
    logic                empty_s;
    logic                inc_s;
    logic                dec_s;
    logic                fpu_in_valid_s;
    logic                issue_ready_s;
    logic                csr_valid_s;
    logic                csr_accept_s;
    logic                fpu_out_ready_s;
    logic                in_csr_wb_s;
    wb_src_t             wb_src_s;
    logic                wb_valid_s;
    logic [ID_WIDTH-1:0] wb_id_s;
    logic [31:0]         wb_data_s;

    fpu_ss_outstanding_cnt #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .inc   (inc_s),
        .dec   (dec_s),
        .cnt   (outstanding_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // CSR instruction ID and CSR read data capture
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_id_r <= '0;
            data_r   <= 32'd0;
        end else begin
            if (csr_accept_s) begin
                csr_id_r <= bus.issue_id_i;
            end
            if ((state_r == ST_RESP) && bus.csr_wb_i) begin
                data_r <= bus.csr_rdata_i;
            end
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (csr_accept_s) state_nxt_s = ST_DRAIN;
                else              state_nxt_s = ST_IDLE;
            end
            ST_DRAIN: begin
                if (empty_s) state_nxt_s = ST_RESP;
                else         state_nxt_s = ST_DRAIN;
            end
            ST_RESP: begin
                if (bus.csr_wb_i) state_nxt_s = ST_CSR_WB;
                else              state_nxt_s = ST_IDLE;
            end
            ST_CSR_WB: begin
                if (bus.wb_ready_i) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_CSR_WB;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM outputs: issue/dispatch handshake and the CSR pop strobe
    always_comb begin
        fpu_in_valid_s = 1'b0;
        issue_ready_s  = 1'b0;
        csr_valid_s    = 1'b0;
        csr_accept_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.issue_is_csr_i) begin
                    issue_ready_s = bus.issue_valid_i;
                    csr_accept_s  = bus.issue_valid_i;
                end else begin
                    fpu_in_valid_s = bus.issue_valid_i && !full_s;
                    issue_ready_s  = fpu_in_valid_s && bus.fpu_in_ready_i;
                end
            end
            ST_DRAIN: begin
                if (empty_s) csr_valid_s = 1'b1;
                else         csr_valid_s = 1'b0;
            end
            default: begin
                csr_valid_s = 1'b0;
            end
        endcase
    end

    // Result acceptance; integer results are backpressured by the writeback port
    always_comb begin
        fpu_out_ready_s = 1'b0;
        if (bus.fpu_out_valid_i) begin
            if (bus.fpu_out_int_i) fpu_out_ready_s = bus.wb_ready_i;
            else                   fpu_out_ready_s = 1'b1;
        end else begin
            fpu_out_ready_s = 1'b0;
        end
    end

    // Writeback source select: a pending CSR writeback owns the port outright
    always_comb begin
        wb_src_s = WB_SRC_NONE;
        if (state_r == ST_CSR_WB) begin
            wb_src_s = WB_SRC_CSR;
        end else if (bus.fpu_out_valid_i && bus.fpu_out_int_i) begin
            wb_src_s = WB_SRC_FPU;
        end else begin
            wb_src_s = WB_SRC_NONE;
        end
    end

    // Writeback mux
    always_comb begin
        wb_valid_s = 1'b0;
        wb_id_s    = '0;
        wb_data_s  = 32'd0;
        case (wb_src_s)
            WB_SRC_CSR: begin
                wb_valid_s = 1'b1;
                wb_id_s    = csr_id_r;
                wb_data_s  = data_r;
            end
            WB_SRC_FPU: begin
                wb_valid_s = 1'b1;
                wb_id_s    = bus.fpu_out_id_i;
                wb_data_s  = bus.fpu_out_data_i;
            end
            default: begin
                wb_valid_s = 1'b0;
            end
        endcase
    end

    assign inc_s       = fpu_in_valid_s && bus.fpu_in_ready_i;
    assign dec_s       = bus.fpu_out_valid_i && fpu_out_ready_s;
    assign in_csr_wb_s = (state_r == ST_CSR_WB);

    assign bus.issue_ready_o   = issue_ready_s;
    assign bus.fpu_in_valid_o  = fpu_in_valid_s;
    assign bus.fpu_out_ready_o = fpu_out_ready_s;
    assign bus.csr_valid_o     = csr_valid_s;
    assign bus.csr_id_o        = csr_id_r;
    assign bus.wb_valid_o      = wb_valid_s;
    assign bus.wb_id_o         = wb_id_s;
    assign bus.wb_data_o       = wb_data_s;
    assign bus.busy_o          = (state_r != ST_IDLE) || !empty_s;

    fpu_ss_csr_seq_chk u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_csr_wb    (in_csr_wb_s),
        .fpu_out_valid(bus.fpu_out_valid_i),
        .fpu_out_int  (bus.fpu_out_int_i),
        .cnt_empty    (empty_s)
    );
endmodule
